irq_controller: RTL

IRQ_CONTROLLER -- requirements
Module: irq_controller

---
 rtl/irq_controller.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/irq_controller.sv
// irq_controller: prioritised interrupt controller with a four-word
// register window (PENDING/MASK/MODE/STATUS) and an IDLE/REQ/SERVICE FSM.
module irq_controller #(
    parameter int                NUM_IRQ   = 8,
    parameter int                ADDR_W    = 12,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 12'h230
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic [ADDR_W-1:0]  bus_addr,
    input  logic [15:0]        bus_wdata,
    input  logic               bus_wr,
    input  logic               intack,
    output logic [15:0]        bus_rdata,
    output logic               reg_hit,
    output logic               int_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_SERVICE
    } state_t;

    state_t             state_q;
    logic [NUM_IRQ-1:0] irq_q;
    logic [NUM_IRQ-1:0] rise_q;
    logic [NUM_IRQ-1:0] pend_q;
    logic [NUM_IRQ-1:0] pend_d;
    logic [NUM_IRQ-1:0] mask_q;
    logic [NUM_IRQ-1:0] mode_q;
    logic [7:0]         vector_q;
    logic               in_service_q;

    logic [ADDR_W-1:0]  off;
    logic               in_range;
    logic [1:0]         sel;
    logic               wr_pend;
    logic               wr_mask;
    logic               wr_mode;
    logic               wr_eoi;
    logic [NUM_IRQ-1:0] wdata_n;
    logic [NUM_IRQ-1:0] w1c;
    logic [NUM_IRQ-1:0] ack_clr;
    logic [NUM_IRQ-1:0] pending_w;
    logic [NUM_IRQ-1:0] pm;
    logic               pm_any;
    logic [7:0]         prio;
    logic               unused_wdata;

    // The window is four words starting at BASE_ADDR; wrap-around of the
    // subtraction puts every address below the base out of range.
    assign off      = bus_addr - BASE_ADDR;
    assign in_range = (off < ADDR_W'(4));
    assign sel      = off[1:0];
    assign reg_hit  = in_range | intack;

    assign wr_pend  = bus_wr & in_range & (sel == 2'd0);
    assign wr_mask  = bus_wr & in_range & (sel == 2'd1);
    assign wr_mode  = bus_wr & in_range & (sel == 2'd2);
    assign wr_eoi   = bus_wr & in_range & (sel == 2'd3);

    assign wdata_n      = bus_wdata[NUM_IRQ-1:0];
    assign unused_wdata = ^bus_wdata;
    assign w1c          = wr_pend ? wdata_n : '0;

    // Edge channels hold a latched bit; level channels mirror irq_q.
    assign pending_w = (mode_q & pend_q) | (~mode_q & irq_q);
    assign pm        = pending_w & mask_q;
    assign pm_any    = |pm;

    // Lowest set index wins: scan downwards so index 0 is assigned last.
    always_comb begin
        prio = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (pm[i]) begin
                prio = 8'(i);
            end
        end
    end

    // Acknowledge clears the frozen vector's bit (edge channels only).
    always_comb begin
        ack_clr = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            ack_clr[i] = (state_q == S_REQ) & intack
                         & (vector_q == 8'(i));
        end
    end

    // A registered rise event sets the bit; it beats a same-cycle W1C.
    assign pend_d = mode_q & ((pend_q & ~w1c & ~ack_clr) | rise_q);

    // Input sampling, rise detection and the software-visible registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_q  <= '0;
            rise_q <= '0;
            pend_q <= '0;
            mask_q <= '0;
            mode_q <= '0;
        end else begin
            irq_q  <= irq;
            rise_q <= irq & ~irq_q;
            pend_q <= pend_d;
            if (wr_mask) begin
                mask_q <= wdata_n;
            end
            if (wr_mode) begin
                mode_q <= wdata_n;
            end
        end
    end

    // Request/service FSM with registered int_o, in_service and vector.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            int_o        <= 1'b0;
            in_service_q <= 1'b0;
            vector_q     <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (pm_any) begin
                        state_q  <= S_REQ;
                        int_o    <= 1'b1;
                        vector_q <= prio;
                    end
                end
                S_REQ: begin
                    if (intack) begin
                        state_q      <= S_SERVICE;
                        int_o        <= 1'b0;
                        in_service_q <= 1'b1;
                    end else if (pm_any) begin
                        vector_q <= prio;
                    end else begin
                        state_q <= S_IDLE;
                        int_o   <= 1'b0;
                    end
                end
                S_SERVICE: begin
                    if (wr_eoi) begin
                        state_q      <= S_IDLE;
                        in_service_q <= 1'b0;
                    end
                end
                default: begin
                    state_q      <= S_IDLE;
                    int_o        <= 1'b0;
                    in_service_q <= 1'b0;
                end
            endcase
        end
    end

    // Read mux: acknowledge returns the vector ahead of any decode.
    always_comb begin
        bus_rdata = '0;
        if (intack) begin
            bus_rdata = {8'h00, vector_q};
        end else if (in_range) begin
            case (sel)
                2'd0:    bus_rdata = 16'(pending_w);
                2'd1:    bus_rdata = 16'(mask_q);
                2'd2:    bus_rdata = 16'(mode_q);
                default: bus_rdata = {in_service_q, 7'b0, vector_q};
            endcase
        end
    end

endmodule
